k2red_kinv2_precomp: RTL and testbench

- Iterative pre-scaler that cancels the k^2 factor left by the K2RED shift reducer for Proth primes q = k*2^m + 1.
- Since k*2^m ≡ -1 (mod q), k^-2 ≡ 2^(2m) (mod q). The block computes Bp = B*2^(2m) mod q by repeated modular doubling.
- Sits on the operand side of the multiplier: A*Bp fed to the K2RED reducer yields A*B mod q, with no k^2 correction needed.
- Start/busy/done handshake, multi-cycle, one result in flight.

---
 rtl/k2red_kinv2_precomp_if.sv | 17 +
 rtl/k2red_kinv2_precomp.sv | 113 +++++++++++
 tb/tb_k2red_kinv2_precomp.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/k2red_kinv2_precomp_if.sv
// Start/busy/done handshake bundle for the k^-2 pre-scaler; master drives
// operands and start, slave returns busy, done and the scaled operand Bp.
interface k2red_kinv2_precomp_if #(
   parameter int W  = 32,
   parameter int MW = 6
);
   logic          start;
   logic [W-1:0]  B;
   logic [W-1:0]  Q;
   logic [MW-1:0] m;
   logic          busy;
   logic          done;
   logic [W-1:0]  Bp;

   modport master (output start, B, Q, m, input busy, done, Bp);
   modport slave  (input start, B, Q, m, output busy, done, Bp);
endinterface

// File: rtl/k2red_kinv2_precomp.sv
// Pre-scaler Bp = B*2^(2m) mod Q, cancelling the k^2 left by K2RED for Proth q.
// Optional: define K2RED_KINV2_RADIX4_EN to apply two doublings per RUN cycle.
module k2red_kinv2_precomp #(
   parameter int W  = 32,
   parameter int MW = 6
) (
   input logic                clk,
   input logic                rst,
   k2red_kinv2_precomp_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t        r_state;
   state_t        w_stateNext;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_q;
   logic [MW-1:0] r_m;
   logic [W-1:0]  r_r;
   logic [MW:0]   r_cnt;
   logic [W-1:0]  r_bp;
   logic          r_busy;
   logic          r_done;
   logic [W-1:0]  w_loadRed;
   logic [W-1:0]  w_runNext;
   logic [MW:0]   w_cntInit;

   // Compare and subtract at W+1 bits so a doubled value never overflows when Q > 2^(W-1).
   function automatic logic [W-1:0] modDouble(input logic [W-1:0] a, input logic [W-1:0] q);
      logic [W:0] t;
      logic [W:0] d;
      t = {a, 1'b0};
      d = t - {1'b0, q};
      if (t >= {1'b0, q}) begin
         modDouble = d[W-1:0];
      end else begin
         modDouble = t[W-1:0];
      end
   endfunction

   assign w_loadRed = (r_b >= r_q) ? (r_b - r_q) : r_b;

`ifdef K2RED_KINV2_RADIX4_EN
   assign w_runNext = modDouble(modDouble(r_r, r_q), r_q);
   assign w_cntInit = {1'b0, r_m};
`else
   assign w_runNext = modDouble(r_r, r_q);
   assign w_cntInit = {r_m, 1'b0};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_stateNext = LOAD;
         LOAD:    w_stateNext = RUN;
         RUN:     if (r_cnt == '0) w_stateNext = DONE;
         DONE:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // busy and done are registered from the next state so they line up with the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_b    <= '0;
         r_q    <= '0;
         r_m    <= '0;
         r_r    <= '0;
         r_cnt  <= '0;
         r_bp   <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_stateNext != IDLE);
         r_done <= (r_state == RUN) && (r_cnt == '0);
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_b <= bus.B;
                  r_q <= bus.Q;
                  r_m <= bus.m;
               end
            end
            LOAD: begin
               r_r   <= w_loadRed;
               r_cnt <= w_cntInit;
            end
            RUN: begin
               if (r_cnt != '0) begin
                  r_r   <= w_runNext;
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_bp <= r_r;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.Bp   = r_bp;

endmodule

// File: tb/tb_k2red_kinv2_precomp.sv
// Directed self-checking bench for k2red_kinv2_precomp with hand-computed Proth vectors.
module tb_k2red_kinv2_precomp;

   localparam logic [31:0] QP = 32'd2148794369;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   k2red_kinv2_precomp_if #(.W(32), .MW(6)) bus ();

   k2red_kinv2_precomp #(.W(32), .MW(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int expLat(input int mm);
`ifdef K2RED_KINV2_RADIX4_EN
      return mm + 2;
`else
      return 2 * mm + 2;
`endif
   endfunction

   task automatic checkOutput(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issues one start and waits (bounded) for done; optionally re-pulses start mid-run.
   task automatic applyStimulus(input logic [31:0] b, input logic [31:0] q, input logic [5:0] mm,
                                input int pulseAt, output int lat);
      @(negedge clk);
      bus.B     = b;
      bus.Q     = q;
      bus.m     = mm;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 400; n++) begin
         if (n == pulseAt) begin
            bus.start = 1'b1;
            bus.B     = b + 32'd1;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = n;
            break;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic runCheck(input string tag, input logic [31:0] b, input logic [31:0] q,
                           input logic [5:0] mm, input logic [31:0] expBp, input int pulseAt);
      int lat;
      applyStimulus(b, q, mm, pulseAt, lat);
      checkOutput({tag, "_lat"}, lat, expLat(int'(mm)));
      checkOutput({tag, "_bp"}, bus.Bp, expBp);
      @(posedge clk);
      #1;
      checkOutput({tag, "_doneLow"}, bus.done, 0);
      checkOutput({tag, "_busyLow"}, bus.busy, 0);
      checkOutput({tag, "_bpHeld"}, bus.Bp, expBp);
   endtask

   initial begin
      bit sawDone;
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.B     = '0;
      bus.Q     = '0;
      bus.m     = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_done", bus.done, 0);
      checkOutput("rst_bp", bus.Bp, 0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("idle_busy", bus.busy, 0);
         checkOutput("idle_done", bus.done, 0);
         checkOutput("idle_bp", bus.Bp, 0);
      end

      runCheck("proth_b1", 32'd1, QP, 6'd17, 32'd2138308601, 0);
      runCheck("proth_b2", 32'd2, QP, 6'd17, 32'd2127822833, 0);
      runCheck("proth_b0", 32'd0, QP, 6'd17, 32'd0, 0);
      runCheck("m0_qm1", QP - 32'd1, QP, 6'd0, 32'd2148794368, 0);
      runCheck("m0_q", QP, QP, 6'd0, 32'd0, 0);
      runCheck("k1_q17", 32'd3, 32'd17, 6'd4, 32'd3, 0);
      runCheck("mid_start", 32'd1, QP, 6'd17, 32'd2138308601, 5);

      // Abort a run with reset and confirm no done pulse ever appears.
      @(negedge clk);
      bus.B     = 32'd2;
      bus.Q     = QP;
      bus.m     = 6'd17;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_busy", bus.busy, 0);
      checkOutput("abort_done", bus.done, 0);
      checkOutput("abort_bp", bus.Bp, 0);
      rst = 1'b0;
      sawDone = 1'b0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (bus.done) sawDone = 1'b1;
      end
      checkOutput("abort_noDone", sawDone, 0);

      runCheck("after_abort", 32'd1, QP, 6'd17, 32'd2138308601, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
